// File: rtl/ads8688_spi_responder.sv
// ADS8688-style SPI responder: receives a 16-bit command in the first half of a
// 32-clock frame and returns the selected channel's 16-bit value in the second.
// SPI pins are asynchronous and pass through 2-flop synchronizers. All frame
// handling is driven by edges seen on the synchronized copies.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// WAIT_HIGH | after reset, wait until cs_n is seen high before any frame
// IDLE      | cs_n high, waiting for its falling edge
// FRAME     | cs_n low, counting SCLK edges, shifting command in and data out
module ads8688_spi_responder #(
  parameter int NUM_CH     = 8,
  parameter int FRAME_BITS = 32
) (
  input  logic                  clk48mhz,
  input  logic                  rstn,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  input  logic [16*NUM_CH-1:0]  ch_data,
  output logic [2:0]            active_ch,
  output logic [15:0]           last_cmd,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  unknown_cmd,
  output logic [15:0]           frame_count
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2
  } state_t;

  logic        sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic        cs_s1_q, cs_s2_q, cs_prev_q;
  logic        sdi_s1_q, sdi_s2_q;

  state_t      state_q, state_d;
  logic [5:0]  rise_cnt_q, rise_cnt_d;
  logic [5:0]  fall_cnt_q, fall_cnt_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        sdo_q, sdo_d;
  logic [2:0]  active_ch_q, active_ch_d;
  logic [15:0] last_cmd_q, last_cmd_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_error_q, frame_error_d;
  logic        unknown_cmd_q, unknown_cmd_d;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [5:0]  fall_next;
  logic        cmd_known;

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
  assign cs_rise   = cs_s2_q & ~cs_prev_q;
  assign cs_fall   = ~cs_s2_q & cs_prev_q;

  // Next-state, counters, shift registers and output pulses.
  always_comb begin
    state_d       = state_q;
    rise_cnt_d    = rise_cnt_q;
    fall_cnt_d    = fall_cnt_q;
    tx_d          = tx_q;
    rx_d          = rx_q;
    sdo_d         = sdo_q;
    active_ch_d   = active_ch_q;
    last_cmd_d    = last_cmd_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    unknown_cmd_d = 1'b0;
    fall_next     = (fall_cnt_q == 6'd63) ? fall_cnt_q : fall_cnt_q + 6'd1;
    cmd_known     = (rx_q[15:13] == 3'b110) || (rx_q == 16'h8500) || (rx_q == 16'h0000);

    // Channel selection lands the cycle after frame_done, from the latched command.
    if (frame_done_q) begin
      if (last_cmd_q[15:13] == 3'b110) begin
        active_ch_d = last_cmd_q[12:10];
      end else if (last_cmd_q == 16'h8500) begin
        active_ch_d = 3'd0;
      end
    end

    case (state_q)
      WAIT_HIGH: begin
        sdo_d = 1'b0;
        if (cs_s2_q) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall) begin
          state_d    = FRAME;
          rise_cnt_d = 6'd0;
          fall_cnt_d = 6'd0;
          tx_d       = ch_data[{active_ch_q, 4'b0000} +: 16];
          rx_d       = 16'h0000;
        end
      end
      FRAME: begin
        if (cs_rise) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
          if (rise_cnt_q == 6'(FRAME_BITS)) begin
            frame_done_d  = 1'b1;
            last_cmd_d    = rx_q;
            frame_count_d = frame_count_q + 16'd1;
            unknown_cmd_d = ~cmd_known;
          end else begin
            frame_error_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (rise_cnt_q < 6'd16) begin
            rx_d = {rx_q[14:0], sdi_s2_q};
          end
          if (rise_cnt_q != 6'd63) begin
            rise_cnt_d = rise_cnt_q + 6'd1;
          end
        end else if (sclk_fall) begin
          fall_cnt_d = fall_next;
          // Falls 16..31 present the snapshot MSB first; everything else drives 0.
          if ((fall_next >= 6'd16) && (fall_next <= 6'd31)) begin
            sdo_d = tx_q[15];
            tx_d  = {tx_q[14:0], 1'b0};
          end else begin
            sdo_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = WAIT_HIGH;
        sdo_d   = 1'b0;
      end
    endcase
  end

  // Synchronizers and all registered state, with synchronous active-low reset.
  always_ff @(posedge clk48mhz) begin
    if (!rstn) begin
      sclk_s1_q     <= 1'b0;
      sclk_s2_q     <= 1'b0;
      sclk_prev_q   <= 1'b0;
      cs_s1_q       <= 1'b0;
      cs_s2_q       <= 1'b0;
      cs_prev_q     <= 1'b0;
      sdi_s1_q      <= 1'b0;
      sdi_s2_q      <= 1'b0;
      state_q       <= WAIT_HIGH;
      rise_cnt_q    <= 6'd0;
      fall_cnt_q    <= 6'd0;
      tx_q          <= 16'h0000;
      rx_q          <= 16'h0000;
      sdo_q         <= 1'b0;
      active_ch_q   <= 3'd0;
      last_cmd_q    <= 16'h0000;
      frame_count_q <= 16'h0000;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      unknown_cmd_q <= 1'b0;
    end else begin
      sclk_s1_q     <= spi_sclk;
      sclk_s2_q     <= sclk_s1_q;
      sclk_prev_q   <= sclk_s2_q;
      cs_s1_q       <= spi_cs_n;
      cs_s2_q       <= cs_s1_q;
      cs_prev_q     <= cs_s2_q;
      sdi_s1_q      <= spi_sdi;
      sdi_s2_q      <= sdi_s1_q;
      state_q       <= state_d;
      rise_cnt_q    <= rise_cnt_d;
      fall_cnt_q    <= fall_cnt_d;
      tx_q          <= tx_d;
      rx_q          <= rx_d;
      sdo_q         <= sdo_d;
      active_ch_q   <= active_ch_d;
      last_cmd_q    <= last_cmd_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      unknown_cmd_q <= unknown_cmd_d;
    end
  end

  assign spi_sdo     = sdo_q;
  assign active_ch   = active_ch_q;
  assign last_cmd    = last_cmd_q;
  assign frame_count = frame_count_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign unknown_cmd = unknown_cmd_q;

endmodule
